// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard sequencer: FSM encoding,
// the hard-wired zero register and default parameter values.
package pipeline_hazard_ctrl_pkg;

    localparam int CNT_W_DEFAULT      = 32;
    localparam int MD_TIMEOUT_DEFAULT = 64;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Two-state sequencer: normal flow or waiting on the iterative MUL/DIV unit
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    // True when an ID source operand is read and names the given register
    function automatic logic src_match(input logic use_src,
                                       input logic [4:0] src,
                                       input logic [4:0] rd);
        return use_src && (src == rd);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Enable-increment counter that sticks at all-ones instead of wrapping.
module pipeline_hazard_ctrl_sat_counter
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on enable, hold once every bit is set
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: redirect flush,
// MUL/DIV handshake with timeout abort, load-use interlock and
// saturating performance counters.
//
// MUL/DIV handshake: md_start is a one-cycle request issued from RUN when
// the EX instruction needs the unit; the unit answers with a one-cycle
// md_done while we sit in MD_BUSY. md_abort is a one-cycle cancel issued
// from MD_BUSY on a redirect or timeout. md_done seen in RUN is ignored.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic [4:0]       rdE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             MdReqE,
    input  logic             md_done,
    input  logic             BranchTakenM,
    input  logic             JumpM,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             md_start,
    output logic             md_abort,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] md_cnt,
    output logic [0:0]       o_dbg_state
);

    localparam int TO_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    logic [0:0]      r_state;
    logic [TO_W-1:0] r_timeout;
    logic            r_md_err;

    logic [0:0]      w_state_nxt;
    logic [TO_W-1:0] w_timeout_nxt;
    logic            w_err_set;
    logic            w_redirect;
    logic            w_load_use;
    logic            w_stall_inc;
    logic            w_flush_inc;
    logic            w_md_inc;

    assign w_redirect = BranchTakenM | JumpM;

    // A load to x0 never produces a value, so it can never cause a stall
    assign w_load_use = MemtoRegE && RegWriteE && (rdE != REG_X0) &&
                        (src_match(useRs1D, rs1D, rdE) || src_match(useRs2D, rs2D, rdE));

    // Control outputs and next-state, priority: redirect, MD start, MD busy, load-use
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        md_start      = 1'b0;
        md_abort      = 1'b0;
        w_state_nxt   = r_state;
        w_timeout_nxt = r_timeout;
        w_err_set     = 1'b0;
        w_flush_inc   = 1'b0;
        w_md_inc      = 1'b0;
        if (reset) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (w_redirect) begin
            // The older control transfer kills everything younger, including MUL/DIV
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
            md_abort      = (r_state == ST_MD_BUSY);
            w_state_nxt   = ST_RUN;
            w_timeout_nxt = '0;
            w_flush_inc   = 1'b1;
        end else if (r_state == ST_RUN) begin
            if (MdReqE) begin
                md_start      = 1'b1;
                PCWrite       = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                flush_ex_mem  = 1'b1;
                w_state_nxt   = ST_MD_BUSY;
                w_timeout_nxt = '0;
            end else if (w_load_use) begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                flush_id_ex = 1'b1;
            end
        end else begin
            if (md_done) begin
                // Enables open so EX/MEM captures the unit's result on this edge
                w_state_nxt   = ST_RUN;
                w_timeout_nxt = '0;
                w_md_inc      = 1'b1;
            end else begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                flush_ex_mem = 1'b1;
                if (r_timeout == TO_LAST) begin
                    // Give up; the instruction stays in EX and re-requests from RUN
                    md_abort      = 1'b1;
                    w_err_set     = 1'b1;
                    w_state_nxt   = ST_RUN;
                    w_timeout_nxt = '0;
                end else begin
                    w_timeout_nxt = r_timeout + 1'b1;
                end
            end
        end
    end

    assign w_stall_inc = !reset && !PCWrite;

    // FSM state and busy-cycle timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_timeout <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_err <= 1'b0;
        end else if (w_err_set) begin
            r_md_err <= 1'b1;
        end
    end

    assign md_err      = r_md_err;
    assign o_dbg_state = r_state;

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_flush_inc),
        .o_count (flush_cnt)
    );

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_md_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (w_md_inc),
        .o_count (md_cnt)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage RV32IM pipeline.
- Replaces the stubbed hazard wiring with three functions:
  - load-use interlock;
  - redirect flush for branches/jumps resolved in MEM;
  - handshake FSM for the multi-cycle iterative MUL/DIV unit in EX.
- Also keeps saturating performance counters for the evaluation flow.
- Instantiated once at the datapath top level. Drives PC enable, pipeline-register write enables and pipeline-register flushes.

Parameters:
- MD_TIMEOUT, 64, max cycles spent in MD_BUSY before forced abort.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rs1D  in  5  rs1 field of the instruction in ID.
- rs2D  in  5  rs2 field of the instruction in ID.
- useRs1D  in  1  ID instruction reads rs1.
- useRs2D  in  1  ID instruction reads rs2.
- rdE  in  5  destination register of the EX instruction.
- RegWriteE  in  1  EX instruction writes the register file.
- MemtoRegE  in  1  EX instruction is a load.
- MdReqE  in  1  EX instruction needs the iterative MUL/DIV unit.
- md_done  in  1  iterative unit result valid this cycle.
- BranchTakenM  in  1  taken branch resolved in MEM.
- JumpM  in  1  jump in MEM.
- PCWrite  out  1  PC register enable.
- IF_ID_Write  out  1  IF/ID enable.
- ID_EX_Write  out  1  ID/EX enable.
- flush_if_id  out  1  load bubble into IF/ID.
- flush_id_ex  out  1  load bubble into ID/EX.
- flush_ex_mem  out  1  load bubble into EX/MEM.
- md_start  out  1  one-cycle start pulse to the iterative unit.
- md_abort  out  1  one-cycle abort pulse to the iterative unit.
- md_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  cycles with PCWrite=0.
- flush_cnt  out  CNT_W  redirect events.
- md_cnt  out  CNT_W  completed MUL/DIV operations.

Behaviour:
- FSM states:
  - RUN: reset state.
  - MD_BUSY.
- Registered state: state, timeout counter, md_err, the three perf counters. All control outputs are combinational from state and inputs.
- Reset asserted, regardless of clock:
  - state=RUN, timeout counter=0, md_err=0, all counters=0.
  - PCWrite=IF_ID_Write=ID_EX_Write=0.
  - All three flushes=1.
  - md_start=md_abort=0.
- Default in RUN with no hazard: all enables 1, all flushes 0.
- Priority, highest first:
  1. Redirect. redirect = BranchTakenM | JumpM.
     - flush_if_id=flush_id_ex=flush_ex_mem=1.
     - PCWrite=1, enables 1.
     - In MD_BUSY: md_abort=1 and next state is RUN, because the older branch kills the younger MUL/DIV.
     - md_start is suppressed.
     - flush_cnt+1.
  2. MUL/DIV in RUN with MdReqE=1:
     - md_start=1, next state MD_BUSY.
     - PCWrite=IF_ID_Write=ID_EX_Write=0, flush_ex_mem=1.
  3. MD_BUSY:
     - md_done=0: same stall/bubble as in item 2; timeout counter +1.
     - md_done=1: all enables 1, flush_ex_mem=0, so EX/MEM captures the result this edge. Next state RUN, md_cnt+1, timeout counter cleared.
     - Timeout counter reaching MD_TIMEOUT-1 with md_done=0: md_abort=1, md_err set (sticky until reset), next state RUN, bubble kept this cycle. The instruction remains in EX and re-requests.
  4. Load-use, RUN only. Hazard when MemtoRegE & RegWriteE & rdE!=0 & ((useRs1D & rs1D==rdE) | (useRs2D & rs2D==rdE)).
     - PCWrite=0, IF_ID_Write=0, flush_id_ex=1.
     - Exactly one stall cycle.
     - rdE=x0 never stalls.
- Load-use and MdReqE are mutually exclusive: one EX instruction cannot be both.
- md_done observed in RUN is ignored; it does not affect counters.
- md_start is never asserted in two consecutive cycles for the same instruction.
- stall_cnt increments every non-reset cycle with PCWrite=0.
- All counters saturate at all-ones and do not wrap.
- Reset mid-MD_BUSY: returns to RUN immediately. md_abort is not pulsed; the unit is reset by the same reset.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_RUN, ST_MD_BUSY);
  - REG_X0 constant;
  - default CNT_W.
- Natural sub-module: sat_counter (CNT_W-bit enable-increment saturating counter), instantiated three times.

Test Plan:
- Load-use: lw x5 in EX (MemtoRegE=1, RegWriteE=1, rdE=5), ID rs1D=5, useRs1D=1 -> PCWrite=0, IF_ID_Write=0, flush_id_ex=1 for exactly 1 cycle; stall_cnt=1. Same stimulus with rdE=0 -> no stall.
- DIV latency: MdReqE=1 at cycle 0, md_done at cycle 33 -> md_start pulse only at cycle 0; PCWrite=0 and flush_ex_mem=1 for cycles 0-32; enables 1 and flush_ex_mem=0 at cycle 33; md_cnt=1, stall_cnt=33.
- Redirect during MD_BUSY: BranchTakenM=1 at cycle 5 of a divide -> md_abort=1 and all three flushes=1 that cycle; state RUN next; flush_cnt=1, md_cnt=0.
- Timeout with MD_TIMEOUT=8: md_done held 0 -> md_abort and md_err at cycle 8 after start; md_start re-pulses next cycle since MdReqE is still 1; md_err stays 1.
- Async reset mid-BUSY: reset asserted between clock edges -> flushes=1 and enables=0 immediately; all counters and md_err read 0.
- Saturation with CNT_W=4: 20 consecutive stall cycles -> stall_cnt holds 15.
